// File: rtl/cg_memory_arbiter_if.sv
// cg_memory_interface: simple valid/ready memory port with independent
// read-address, read-data and write channels.
//   to_memory   : view of a requester driving a memory
//   from_memory : view of a block acting as the memory for a requester
interface cg_memory_interface #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  raddr_valid;
    logic                  raddr_ready;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  rdata_valid;
    logic                  rdata_ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  wdata_valid;
    logic                  wdata_ready;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    modport to_memory (
        output raddr_valid, raddr, rdata_ready, wdata_valid, wen, waddr, wdata,
        input  raddr_ready, rdata_valid, rdata, wdata_ready
    );

    modport from_memory (
        input  raddr_valid, raddr, rdata_ready, wdata_valid, wen, waddr, wdata,
        output raddr_ready, rdata_valid, rdata, wdata_ready
    );
endinterface

// File: rtl/cg_memory_arbiter.sv
// cg_memory_arbiter: shares one downstream memory port between two clients.
// Read-address and write channels are arbitrated independently, round-robin,
// with a grant lock that holds a stalled handshake on its owner. Read data
// returns in order and is steered by an ID FIFO recording who issued each read.
// Ports:
//   clk   - clock, all state on rising edge
//   rst_n - synchronous active-low reset
//   c0/c1 - client ports (arbiter acts as their memory)
//   mem   - shared downstream memory port
module cg_memory_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    cg_memory_interface.from_memory      c0,
    cg_memory_interface.from_memory      c1,
    cg_memory_interface.to_memory        mem
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                       rd_prio_r, rd_lock_r, rd_owner_r;
    logic                       wr_prio_r, wr_lock_r, wr_owner_r;
    logic [MAX_OUTSTANDING-1:0] id_mem_r;
    logic [PTR_W-1:0]           rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]           count_r;

    logic                  rd_gnt_s, rd_req_s, rd_xfer_s, fifo_full_s, fifo_empty_s;
    logic                  head_id_s, pop_s;
    logic                  wr_gnt_s, wr_req_s, wr_xfer_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s, wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s, rd_data_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end else begin
            return ptr + 1'b1;
        end
    endfunction

    assign fifo_full_s  = (count_r == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty_s = (count_r == '0);
    assign head_id_s    = id_mem_r[rd_ptr_r];

    // Read-address grant: a held lock wins, else single requester, else priority.
    always_comb begin
        rd_gnt_s = 1'b0;
        if (rd_lock_r) begin
            rd_gnt_s = rd_owner_r;
        end else if (c0.raddr_valid && c1.raddr_valid) begin
            rd_gnt_s = rd_prio_r;
        end else if (c1.raddr_valid) begin
            rd_gnt_s = 1'b1;
        end else begin
            rd_gnt_s = 1'b0;
        end
    end

    // Read-address mux; a full FIFO hides the request so no lock forms.
    always_comb begin
        rd_addr_s = rd_gnt_s ? c1.raddr : c0.raddr;
        rd_req_s  = (rd_gnt_s ? c1.raddr_valid : c0.raddr_valid) && !fifo_full_s;
        rd_xfer_s = rd_req_s && mem.raddr_ready;
    end

    assign mem.raddr_valid = rd_req_s;
    assign mem.raddr       = rd_addr_s;
    assign c0.raddr_ready  = !rd_gnt_s && mem.raddr_ready && !fifo_full_s;
    assign c1.raddr_ready  =  rd_gnt_s && mem.raddr_ready && !fifo_full_s;

    // Read data steering: only the FIFO head client sees valid.
    always_comb begin
        rd_data_s = mem.rdata;
        pop_s     = 1'b0;
        if (fifo_empty_s) begin
            pop_s = 1'b0;
        end else begin
            pop_s = mem.rdata_valid && (head_id_s ? c1.rdata_ready : c0.rdata_ready);
        end
    end

    assign c0.rdata        = rd_data_s;
    assign c1.rdata        = rd_data_s;
    assign c0.rdata_valid  = !fifo_empty_s && !head_id_s && mem.rdata_valid;
    assign c1.rdata_valid  = !fifo_empty_s &&  head_id_s && mem.rdata_valid;
    assign mem.rdata_ready = !fifo_empty_s && (head_id_s ? c1.rdata_ready : c0.rdata_ready);

    // Write grant, same lock / round-robin scheme as reads.
    always_comb begin
        wr_gnt_s = 1'b0;
        if (wr_lock_r) begin
            wr_gnt_s = wr_owner_r;
        end else if (c0.wdata_valid && c1.wdata_valid) begin
            wr_gnt_s = wr_prio_r;
        end else if (c1.wdata_valid) begin
            wr_gnt_s = 1'b1;
        end else begin
            wr_gnt_s = 1'b0;
        end
    end

    // Write channel mux.
    always_comb begin
        wr_req_s  = wr_gnt_s ? c1.wdata_valid : c0.wdata_valid;
        wr_addr_s = wr_gnt_s ? c1.waddr : c0.waddr;
        wr_data_s = wr_gnt_s ? c1.wdata : c0.wdata;
        wr_xfer_s = wr_req_s && mem.wdata_ready;
    end

    assign mem.wdata_valid = wr_req_s;
    assign mem.wen         = wr_gnt_s ? c1.wen : c0.wen;
    assign mem.waddr       = wr_addr_s;
    assign mem.wdata       = wr_data_s;
    assign c0.wdata_ready  = !wr_gnt_s && mem.wdata_ready;
    assign c1.wdata_ready  =  wr_gnt_s && mem.wdata_ready;

    // Priorities, grant locks, and FIFO pointers/count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_prio_r  <= 1'b0;
            rd_lock_r  <= 1'b0;
            rd_owner_r <= 1'b0;
            wr_prio_r  <= 1'b0;
            wr_lock_r  <= 1'b0;
            wr_owner_r <= 1'b0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
        end else begin
            if (rd_xfer_s) begin
                rd_lock_r <= 1'b0;
                rd_prio_r <= ~rd_gnt_s;
            end else if (rd_req_s) begin
                rd_lock_r  <= 1'b1;
                rd_owner_r <= rd_gnt_s;
            end
            if (wr_xfer_s) begin
                wr_lock_r <= 1'b0;
                wr_prio_r <= ~wr_gnt_s;
            end else if (wr_req_s) begin
                wr_lock_r  <= 1'b1;
                wr_owner_r <= wr_gnt_s;
            end
            if (rd_xfer_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({rd_xfer_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // ID storage; entries beyond count are don't-care, so no reset needed.
    always_ff @(posedge clk) begin
        if (rd_xfer_s) begin
            id_mem_r[wr_ptr_r] <= rd_gnt_s;
        end
    end
endmodule

// File: tb/tb_cg_memory_arbiter.sv
module tb_cg_memory_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MAXO = 4;

    logic clk;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    cg_memory_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) c0_if ();
    cg_memory_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) c1_if ();
    cg_memory_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

    cg_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .c0    (c0_if),
        .c1    (c1_if),
        .mem   (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a queue of issuing clients, plus who is currently
    // being served on each channel (-1 = nobody mid-handshake).
    int m_q[$];
    int m_rprio = 0, m_wprio = 0, m_rhold = -1, m_whold = -1;

    int          e_rgnt, e_wgnt, e_head;
    bit          e_mem_rvalid, e_mem_rready, e_mem_wvalid, e_wen;
    logic [31:0] e_raddr, e_waddr, e_wdata;
    bit          e_rready[2], e_rdvalid[2], e_wready[2];

    function void compute();
        bit          rv[2], wv[2], rdr[2], wn[2];
        logic [31:0] ra[2], wa[2], wd[2];
        bit          full;
        rv[0] = c0_if.raddr_valid; rv[1] = c1_if.raddr_valid;
        ra[0] = c0_if.raddr;       ra[1] = c1_if.raddr;
        wv[0] = c0_if.wdata_valid; wv[1] = c1_if.wdata_valid;
        wa[0] = c0_if.waddr;       wa[1] = c1_if.waddr;
        wd[0] = c0_if.wdata;       wd[1] = c1_if.wdata;
        wn[0] = c0_if.wen;         wn[1] = c1_if.wen;
        rdr[0] = c0_if.rdata_ready; rdr[1] = c1_if.rdata_ready;
        full = (m_q.size() >= MAXO);
        if (m_rhold >= 0) e_rgnt = m_rhold;
        else if (rv[0] && rv[1]) e_rgnt = m_rprio;
        else e_rgnt = rv[1] ? 1 : 0;
        e_mem_rvalid = rv[e_rgnt] && !full;
        e_raddr = ra[e_rgnt];
        for (int i = 0; i < 2; i++) begin
            e_rready[i] = (i == e_rgnt) && mem_if.raddr_ready && !full;
        end
        e_head = (m_q.size() > 0) ? m_q[0] : -1;
        for (int i = 0; i < 2; i++) begin
            e_rdvalid[i] = (e_head == i) && mem_if.rdata_valid;
        end
        e_mem_rready = (e_head >= 0) ? rdr[e_head] : 1'b0;
        if (m_whold >= 0) e_wgnt = m_whold;
        else if (wv[0] && wv[1]) e_wgnt = m_wprio;
        else e_wgnt = wv[1] ? 1 : 0;
        e_mem_wvalid = wv[e_wgnt];
        e_waddr = wa[e_wgnt];
        e_wdata = wd[e_wgnt];
        e_wen   = wn[e_wgnt];
        for (int i = 0; i < 2; i++) begin
            e_wready[i] = (i == e_wgnt) && mem_if.wdata_ready;
        end
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Model state update on each rising edge.
    always @(posedge clk) begin
        compute();
        if (!rst_n) begin
            m_q.delete();
            m_rprio = 0; m_wprio = 0; m_rhold = -1; m_whold = -1;
        end else begin
            if (e_head >= 0 && mem_if.rdata_valid && e_mem_rready) void'(m_q.pop_front());
            if (e_mem_rvalid) begin
                if (mem_if.raddr_ready) begin
                    m_q.push_back(e_rgnt); m_rhold = -1; m_rprio = 1 - e_rgnt;
                end else m_rhold = e_rgnt;
            end
            if (e_mem_wvalid) begin
                if (mem_if.wdata_ready) begin
                    m_whold = -1; m_wprio = 1 - e_wgnt;
                end else m_whold = e_wgnt;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            compute();
            check("mem.raddr_valid", mem_if.raddr_valid, e_mem_rvalid);
            check("mem.raddr", mem_if.raddr, e_raddr);
            check("c0.raddr_ready", c0_if.raddr_ready, e_rready[0]);
            check("c1.raddr_ready", c1_if.raddr_ready, e_rready[1]);
            check("c0.rdata_valid", c0_if.rdata_valid, e_rdvalid[0]);
            check("c1.rdata_valid", c1_if.rdata_valid, e_rdvalid[1]);
            check("c0.rdata", c0_if.rdata, mem_if.rdata);
            check("c1.rdata", c1_if.rdata, mem_if.rdata);
            check("mem.rdata_ready", mem_if.rdata_ready, e_mem_rready);
            check("mem.wdata_valid", mem_if.wdata_valid, e_mem_wvalid);
            if (e_mem_wvalid) begin
                check("mem.waddr", mem_if.waddr, e_waddr);
                check("mem.wdata", mem_if.wdata, e_wdata);
                check("mem.wen", mem_if.wen, e_wen);
            end
            check("c0.wdata_ready", c0_if.wdata_ready, e_wready[0]);
            check("c1.wdata_ready", c1_if.wdata_ready, e_wready[1]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c0_if.raddr_valid = 1'b0; c0_if.raddr = 32'h0; c0_if.rdata_ready = 1'b0;
        c0_if.wdata_valid = 1'b0; c0_if.wen = 1'b0; c0_if.waddr = 32'h0; c0_if.wdata = 32'h0;
        c1_if.raddr_valid = 1'b0; c1_if.raddr = 32'h0; c1_if.rdata_ready = 1'b0;
        c1_if.wdata_valid = 1'b0; c1_if.wen = 1'b0; c1_if.waddr = 32'h0; c1_if.wdata = 32'h0;
        mem_if.raddr_ready = 1'b0; mem_if.rdata_valid = 1'b0; mem_if.rdata = 32'h0;
        mem_if.wdata_ready = 1'b0;
    endtask

    task automatic drain(input int n);
        c0_if.rdata_ready = 1'b1; c1_if.rdata_ready = 1'b1;
        mem_if.rdata_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            mem_if.rdata = 32'h5000 + 32'(i);
            cyc();
        end
        mem_if.rdata_valid = 1'b0;
        c0_if.rdata_ready = 1'b0; c1_if.rdata_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        cyc(); cyc();
        rst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        check("reset mem.raddr_valid", mem_if.raddr_valid, 1'b0);
        check("reset mem.rdata_ready", mem_if.rdata_ready, 1'b0);
        check("reset mem.wdata_valid", mem_if.wdata_valid, 1'b0);
        check("reset c0.rdata_valid", c0_if.rdata_valid, 1'b0);
        cyc();

        // Round-robin reads
        c0_if.raddr_valid = 1'b1; c0_if.raddr = 32'h100;
        c1_if.raddr_valid = 1'b1; c1_if.raddr = 32'h200;
        mem_if.raddr_ready = 1'b1;
        #1;
        check("rr first addr", mem_if.raddr, 32'h100);
        check("rr c1 not ready", c1_if.raddr_ready, 1'b0);
        cyc();
        check("rr second addr", mem_if.raddr, 32'h200);
        check("rr c1 ready", c1_if.raddr_ready, 1'b1);
        cyc();
        idle();
        mem_if.rdata_valid = 1'b1; mem_if.rdata = 32'h11;
        c0_if.rdata_ready = 1'b1; c1_if.rdata_ready = 1'b1;
        #1;
        check("rr ret0 c0 valid", c0_if.rdata_valid, 1'b1);
        cyc();
        mem_if.rdata = 32'h22;
        #1;
        check("rr ret1 c1 valid", c1_if.rdata_valid, 1'b1);
        check("rr ret1 c1 data", c1_if.rdata, 32'h22);
        cyc();
        #1;
        check("empty rdata_ready", mem_if.rdata_ready, 1'b0);
        check("empty c0 valid", c0_if.rdata_valid, 1'b0);
        idle();
        cyc();

        // Read lock held by c1 while stalled
        c1_if.raddr_valid = 1'b1; c1_if.raddr = 32'h40;
        #1;
        check("lock addr c1", mem_if.raddr, 32'h40);
        cyc();
        c0_if.raddr_valid = 1'b1; c0_if.raddr = 32'h50;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("lock held addr", mem_if.raddr, 32'h40);
            check("lock c0 blocked", c0_if.raddr_ready, 1'b0);
            cyc();
        end
        mem_if.raddr_ready = 1'b1;
        #1;
        check("lock c1 ready", c1_if.raddr_ready, 1'b1);
        cyc();
        c1_if.raddr_valid = 1'b0;
        #1;
        check("after lock c0 addr", mem_if.raddr, 32'h50);
        cyc();
        c0_if.raddr_valid = 1'b0;
        drain(2);
        idle();

        // In-order return with stall
        mem_if.raddr_ready = 1'b1;
        c0_if.raddr_valid = 1'b1; c0_if.raddr = 32'h10; cyc();
        c0_if.raddr_valid = 1'b0; c1_if.raddr_valid = 1'b1; c1_if.raddr = 32'h20; cyc();
        c1_if.raddr_valid = 1'b0; c0_if.raddr_valid = 1'b1; c0_if.raddr = 32'h30; cyc();
        idle();
        mem_if.rdata_valid = 1'b1; mem_if.rdata = 32'hA; c0_if.rdata_ready = 1'b1;
        #1;
        check("order A to c0", c0_if.rdata_valid, 1'b1);
        cyc();
        mem_if.rdata = 32'hB;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("order B stall", mem_if.rdata_ready, 1'b0);
            check("order B c1 valid", c1_if.rdata_valid, 1'b1);
            cyc();
        end
        c1_if.rdata_ready = 1'b1;
        #1;
        check("order B release", mem_if.rdata_ready, 1'b1);
        cyc();
        mem_if.rdata = 32'hC;
        #1;
        check("order C to c0", c0_if.rdata_valid, 1'b1);
        check("order C data", c0_if.rdata, 32'hC);
        cyc();
        idle();

        // FIFO full
        mem_if.raddr_ready = 1'b1;
        c0_if.raddr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            c0_if.raddr = 32'h1000 + 32'(4 * i);
            #1;
            check("fill accept", c0_if.raddr_ready, 1'b1);
            cyc();
        end
        c0_if.raddr = 32'h1010;
        #1;
        check("full raddr_valid", mem_if.raddr_valid, 1'b0);
        cyc();
        mem_if.rdata_valid = 1'b1; c0_if.rdata_ready = 1'b1;
        #1;
        check("full pop no accept", mem_if.raddr_valid, 1'b0);
        check("full pop ready", mem_if.rdata_ready, 1'b1);
        cyc();
        #1;
        check("push+pop accept", c0_if.raddr_ready, 1'b1);
        cyc();
        mem_if.rdata_valid = 1'b0; c0_if.raddr = 32'h1014;
        #1;
        check("refill accept", c0_if.raddr_ready, 1'b1);
        cyc();
        c0_if.raddr = 32'h1018;
        #1;
        check("full again", mem_if.raddr_valid, 1'b0);
        cyc();
        c0_if.raddr_valid = 1'b0;
        drain(4);
        idle();

        // Writes alternate while a read proceeds
        c0_if.wdata_valid = 1'b1; c0_if.wen = 1'b1; c0_if.waddr = 32'h8; c0_if.wdata = 32'hDEAD;
        c1_if.wdata_valid = 1'b1; c1_if.wen = 1'b1; c1_if.waddr = 32'hC; c1_if.wdata = 32'hBEEF;
        c1_if.raddr_valid = 1'b1; c1_if.raddr = 32'h300;
        mem_if.wdata_ready = 1'b1; mem_if.raddr_ready = 1'b1;
        #1;
        check("wr1 addr", mem_if.waddr, 32'h8);
        check("wr1 data", mem_if.wdata, 32'hDEAD);
        check("wr1 read c1 ready", c1_if.raddr_ready, 1'b1);
        cyc();
        c0_if.wdata_valid = 1'b0; c1_if.raddr_valid = 1'b0;
        #1;
        check("wr2 data", mem_if.wdata, 32'hBEEF);
        check("wr2 c1 ready", c1_if.wdata_ready, 1'b1);
        cyc();
        idle();
        drain(1);

        // Write lock held by c1
        c1_if.wdata_valid = 1'b1; c1_if.wen = 1'b1; c1_if.waddr = 32'h20; c1_if.wdata = 32'h1234;
        cyc();
        c0_if.wdata_valid = 1'b1; c0_if.wen = 1'b1; c0_if.waddr = 32'h24; c0_if.wdata = 32'h5678;
        #1;
        check("wlock addr", mem_if.waddr, 32'h20);
        check("wlock c0 blocked", c0_if.wdata_ready, 1'b0);
        cyc();
        mem_if.wdata_ready = 1'b1;
        cyc();
        c1_if.wdata_valid = 1'b0;
        #1;
        check("wlock then c0", mem_if.waddr, 32'h24);
        cyc();
        idle();

        // Reset mid-operation
        mem_if.raddr_ready = 1'b1;
        c0_if.raddr_valid = 1'b1; c0_if.raddr = 32'h500; cyc();
        c0_if.raddr = 32'h504; cyc();
        c0_if.raddr_valid = 1'b0; mem_if.raddr_ready = 1'b0;
        c1_if.raddr_valid = 1'b1; c1_if.raddr = 32'h600; cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        c1_if.raddr_valid = 1'b0;
        mem_if.rdata_valid = 1'b1; c0_if.rdata_ready = 1'b1; c1_if.rdata_ready = 1'b1;
        #1;
        check("post-reset rdata_ready", mem_if.rdata_ready, 1'b0);
        check("post-reset c0 rvalid", c0_if.rdata_valid, 1'b0);
        cyc();
        idle();
        c0_if.raddr_valid = 1'b1; c0_if.raddr = 32'h700;
        c1_if.raddr_valid = 1'b1; c1_if.raddr = 32'h800;
        #1;
        check("post-reset tie c0", mem_if.raddr, 32'h700);
        mem_if.raddr_ready = 1'b1;
        cyc();
        idle();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
